// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display blocks.
package display_pkg;

  // Largest value that fits on four decimal digits.
  localparam int MAX_VALUE = 9999;

  // A digit code is a BCD nibble plus one sentinel bit for the dash and blank codes.
  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] CODE_DASH  = 5'b10000;
  localparam logic [CODE_W-1:0] CODE_BLANK = 5'b10001;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Conversion controller states.
  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/seg_font.sv
// BCD nibble to active-low seven-segment pattern; non-decimal codes show blank.
module seg_font
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Pure lookup from decimal digit to its segment pattern.
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/segment_driver.sv
// Binary-to-BCD display driver: sequential double-dabble conversion into a held
// display register, then a combinational digit mux with blanking and decimal point.
module segment_driver
  import display_pkg::*;
#(
  parameter int MAX_VALUE = display_pkg::MAX_VALUE,
  parameter int NBITS     = 14
) (
  input  logic             clk_en,
  input  logic             reset,
  input  logic [NBITS-1:0] value,
  input  logic             load,
  input  logic [1:0]       s,
  input  logic             blank_lz,
  input  logic             dp_en,
  input  logic [1:0]       dp_pos,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             busy,
  output logic             ovf
);

  localparam int CW = $clog2(NBITS);

  state_t state, state_next;

  logic [NBITS-1:0]            bin;
  logic [15:0]                 bcd;
  logic [CW-1:0]               count;
  logic [3:0][CODE_W-1:0]      disp;

  logic [15:0]                 bcd_adj;
  logic [15:0]                 bcd_next;
  logic                        too_big;
  logic                        last_iter;

  logic [CODE_W-1:0]           sel_code;
  logic                        sel_blank;
  logic [6:0]                  font_pattern;

  assign too_big   = (value > NBITS'(MAX_VALUE));
  assign last_iter = (count == CW'(NBITS - 1));

  // Controller state register.
  always_ff @(posedge clk_en or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: start on an in-range load, return to idle after the last shift.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (load && !too_big) state_next = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last_iter) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble step: add-3 to every nibble of 5 or more, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 4; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[14:0], bin[NBITS-1]};
  end

  // Conversion datapath, overflow flag and held display register.
  always_ff @(posedge clk_en or posedge reset) begin
    if (reset) begin
      bin   <= '0;
      bcd   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      disp  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            if (too_big) begin
              ovf  <= 1'b1;
              disp <= {4{CODE_DASH}};
            end else begin
              ovf   <= 1'b0;
              bin   <= value;
              bcd   <= '0;
              count <= '0;
            end
          end
        end
        CONV: begin
          bcd   <= bcd_next;
          bin   <= {bin[NBITS-2:0], 1'b0};
          count <= count + 1'b1;
          if (last_iter) begin
            for (int i = 0; i < 4; i++) disp[i] <= {1'b0, bcd_next[4*i +: 4]};
          end
        end
        default: ;
      endcase
    end
  end

  // Leading-zero blanking for the selected digit; the decimal point keeps digits up to it visible.
  always_comb begin
    sel_code  = disp[s];
    sel_blank = blank_lz && (s != 2'd0) && !(dp_en && (s <= dp_pos));
    for (int j = 0; j < 4; j++) begin
      if ((2'(j) >= s) && (disp[j] != '0)) sel_blank = 1'b0;
    end
  end

  seg_font u_font (
    .code    (sel_code[3:0]),
    .pattern (font_pattern)
  );

  // Final segment select: dashes win, then blanking, then the font.
  always_comb begin
    seg = font_pattern;
    if (sel_code == CODE_DASH)       seg = SEG_DASH;
    else if (sel_code == CODE_BLANK) seg = SEG_BLANK;
    else if (sel_blank)              seg = SEG_BLANK;
    dp = !(dp_en && (s == dp_pos));
  end

endmodule

// File: tb/tb_segment_driver.sv
// Directed self-checking bench for segment_driver.
module tb_segment_driver;

  logic        clk_en = 1'b0;
  logic        reset;
  logic [13:0] value;
  logic        load;
  logic [1:0]  s;
  logic        blank_lz;
  logic        dp_en;
  logic [1:0]  dp_pos;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  segment_driver dut (
    .clk_en   (clk_en),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .s        (s),
    .blank_lz (blank_lz),
    .dp_en    (dp_en),
    .dp_pos   (dp_pos),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk_en = ~clk_en;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
    end
  endtask

  // Pulse load for one clk_en edge; returns at the negedge right after the sampling edge.
  task automatic applyStimulus(input logic [13:0] v);
    @(negedge clk_en);
    value = v;
    load  = 1'b1;
    @(negedge clk_en);
    load  = 1'b0;
  endtask

  // Count negedge samples with busy high, bounded.
  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk_en);
    end
  endtask

  task automatic checkDigit(input string tag, input logic [1:0] sel, input logic [6:0] exp_seg);
    s = sel;
    #1;
    checkOutput(tag, 32'(seg), 32'(exp_seg));
  endtask

  int cyc;

  initial begin
    reset = 1'b1; value = '0; load = 1'b0; s = 2'd0;
    blank_lz = 1'b0; dp_en = 1'b0; dp_pos = 2'd0;
    #12;
    checkOutput("reset_seg", 32'(seg), 32'(7'b1000000));
    checkOutput("reset_dp", 32'(dp), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    @(negedge clk_en);
    reset = 1'b0;

    // 1234 without blanking
    applyStimulus(14'd1234);
    waitIdle(cyc);
    checkOutput("busy_cycles_1234", 32'(cyc), 32'd14);
    checkDigit("1234_s0", 2'd0, 7'b0011001);
    checkDigit("1234_s1", 2'd1, 7'b0110000);
    checkDigit("1234_s2", 2'd2, 7'b0100100);
    checkDigit("1234_s3", 2'd3, 7'b1111001);

    // 7 with leading-zero blanking
    blank_lz = 1'b1;
    applyStimulus(14'd7);
    waitIdle(cyc);
    checkDigit("7_s0", 2'd0, 7'b1111000);
    checkDigit("7_s1", 2'd1, 7'b1111111);
    checkDigit("7_s2", 2'd2, 7'b1111111);
    checkDigit("7_s3", 2'd3, 7'b1111111);

    // 250 as " 2.50"
    dp_en = 1'b1; dp_pos = 2'd2;
    applyStimulus(14'd250);
    waitIdle(cyc);
    checkDigit("250_s3", 2'd3, 7'b1111111);
    checkDigit("250_s2", 2'd2, 7'b0100100);
    checkOutput("250_dp2", 32'(dp), 32'd0);
    checkDigit("250_s1", 2'd1, 7'b0010010);
    checkOutput("250_dp1", 32'(dp), 32'd1);
    checkDigit("250_s0", 2'd0, 7'b1000000);

    // 5 as " 0.05"
    applyStimulus(14'd5);
    waitIdle(cyc);
    checkDigit("5_s3", 2'd3, 7'b1111111);
    checkDigit("5_s2", 2'd2, 7'b1000000);
    checkOutput("5_dp2", 32'(dp), 32'd0);
    checkDigit("5_s1", 2'd1, 7'b1000000);
    checkDigit("5_s0", 2'd0, 7'b0010010);

    // Overflow shows dashes, never blanked
    dp_en = 1'b0;
    applyStimulus(14'd10000);
    checkOutput("ovf_flag", 32'(ovf), 32'd1);
    checkOutput("ovf_busy", 32'(busy), 32'd0);
    checkDigit("ovf_s0", 2'd0, 7'b0111111);
    checkDigit("ovf_s1", 2'd1, 7'b0111111);
    checkDigit("ovf_s2", 2'd2, 7'b0111111);
    checkDigit("ovf_s3", 2'd3, 7'b0111111);

    // 42 clears ovf; dashes held until completion
    applyStimulus(14'd42);
    checkOutput("42_ovf_clear", 32'(ovf), 32'd0);
    checkOutput("42_busy", 32'(busy), 32'd1);
    checkDigit("42_held_dash", 2'd0, 7'b0111111);
    waitIdle(cyc);
    checkOutput("busy_cycles_42", 32'(cyc), 32'd14);
    checkDigit("42_s0", 2'd0, 7'b0100100);
    checkDigit("42_s1", 2'd1, 7'b0011001);
    checkDigit("42_s2", 2'd2, 7'b1111111);

    // Load during conversion is ignored
    blank_lz = 1'b0;
    applyStimulus(14'd9876);
    @(negedge clk_en);
    @(negedge clk_en);
    value = 14'd1111;
    load  = 1'b1;
    @(negedge clk_en);
    load  = 1'b0;
    waitIdle(cyc);
    checkOutput("busy_cycles_9876", 32'(cyc), 32'd11);
    checkDigit("9876_s0", 2'd0, 7'b0000010);
    checkDigit("9876_s1", 2'd1, 7'b1111000);
    checkDigit("9876_s2", 2'd2, 7'b0000000);
    checkDigit("9876_s3", 2'd3, 7'b0010000);
    @(negedge clk_en);
    checkOutput("no_queue_busy", 32'(busy), 32'd0);

    // Reset mid-conversion
    applyStimulus(14'd1234);
    repeat (5) @(negedge clk_en);
    reset = 1'b1;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkDigit("midreset_s0", 2'd0, 7'b1000000);
    checkDigit("midreset_s1", 2'd1, 7'b1000000);
    checkDigit("midreset_s2", 2'd2, 7'b1000000);
    checkDigit("midreset_s3", 2'd3, 7'b1000000);
    @(negedge clk_en);
    reset = 1'b0;
    @(negedge clk_en);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
